dff_delay_line: RTL and testbench
=================================

// Module: dff_delay_line
// PURPOSE
//  Parametrised pipeline of D flip-flops with asynchronous active-low reset. Each stage holds a
//  data word and a valid bit, plus a shared clock enable and synchronous clear.
//  Delays a WIDTH-bit stream by DEPTH enabled cycles and keeps a running count of occupied stages.
//  Generalises the single-bit latch / async-DFF / sync-DFF primitives into a reusable
//  retiming and delay-matching block for datapaths.
// PARAMETERS
//  WIDTH    8      data word width in bits (>=1)
//  DEPTH    4      number of register stages = latency in enabled cycles (>=1)
//  RST_VAL  0      data value loaded into every stage on reset or clear (WIDTH bits)
// PORTS
//  clk      in   1                rising-edge clock, the only clock
//  rst_n    in   1                asynchronous active-low reset
//  en       in   1                stage enable; 0 = every stage holds
//  clr      in   1                synchronous clear; overrides en
//  d        in   WIDTH            input data word
//  d_vld    in   1                input valid qualifier
//  q        out  WIDTH            data of last stage (DEPTH-1)
//  q_vld    out  1                valid of last stage
//  cnt      out  $clog2(DEPTH+1)  number of stages holding valid data, 0..DEPTH
//  full     out  1                cnt == DEPTH
//  empty    out  1                cnt == 0
// BEHAVIOUR
//  - Only one clock. Reset is asynchronous and active-low.
//  - Reset: rst_n=0 acts immediately with no clock edge. Every stage data = RST_VAL and every valid = 0.
//    Result: q=RST_VAL, q_vld=0, cnt=0, full=0, empty=1. This holds while rst_n=0.
//  - Release of rst_n takes effect at the next rising clk edge.
//  - Priority at each rising edge: rst_n low > clr > en > hold.
//  - clr=1: all data = RST_VAL, all valids = 0, cnt = 0. d/d_vld are NOT captured, whatever en is.
//  - en=1, clr=0: stage0 <= {d_vld,d}; stage i <= stage i-1 for i=1..DEPTH-1.
//    The last stage's contents are discarded.
//  - en=0, clr=0: all stages, cnt, q and q_vld hold.
//  - Data is captured regardless of d_vld; the valid bit only qualifies it.
//  - Latency: a word sampled at enabled edge k appears on q/q_vld after enabled edge k+DEPTH-1.
//    That is DEPTH enabled edges including the capture edge. Disabled cycles stretch latency.
//  - cnt is a registered counter. On an enabled edge: cnt <= cnt + d_vld - vld[DEPTH-1].
//    Equal-in/equal-out leaves it unchanged. It never wraps.
//    It must equal popcount(vld[]) at every edge; the bench checks this as an assertion.
//  - full and empty are decoded combinationally from cnt.
//  - q, q_vld, cnt, full and empty are driven from registers or cnt decode only. No combinational d->q path.
//  - DEPTH=1: behaves as a single async-reset DFF with enable, clear and valid. q follows d one edge later.
//  - Reset mid-stream discards all in-flight words. There is no replay.
// CONFIGURATION
//  DLY_TAPS_EN defined:
//    - Adds output port taps [WIDTH*DEPTH-1:0] with stage i data at bits [i*WIDTH +: WIDTH].
//    - Adds output port tap_vld [DEPTH-1:0] with the valid bits.
//    - Both follow the same reset and clear rules as the stages. Used for FIR and debug taps.
//  DLY_TAPS_EN undefined: neither port exists. Only the last stage is observable. Behaviour is otherwise identical.
// TESTING  (WIDTH=8, DEPTH=4, RST_VAL=8'h00, clk period 200)
//  1 Reset, async: drive rst_n=0 at t=50 between edges with the pipe holding data
//    -> q=8'h00, q_vld=0, cnt=0, empty=1 at t=51.
//  2 Fill: en=1, d_vld=1, d=A1,A2,A3,A4 on 4 edges
//    -> q=A1 and q_vld=1 after 4th edge; cnt=4, full=1. Next edge with d=A5 -> q=A2, cnt stays 4.
//  3 Hold: after fill, en=0 for 3 edges while d changes
//    -> q, cnt and full unchanged. Then en=1 -> shifting resumes with q=A2 next.
//  4 Clear vs enable: clr=1, en=1, d=FF, d_vld=1 on one edge
//    -> q=00, q_vld=0, cnt=0; FF does not appear 4 edges later.
//  5 Bubbles: en=1, d_vld=1,0,1,0,... with d=10,11,12,13,...
//    -> q_vld shows the same pattern delayed by 4 edges; cnt settles at 2; full and empty stay 0.
//  6 Reset mid-stream: cnt=3, drive rst_n=0 for 1 cycle then release
//    -> immediate clear. New word B0 captured at the first edge after release appears after 4 edges.
//  With DLY_TAPS_EN: repeat test 2 -> taps={A1,A2,A3,A4} MSB to LSB stage order and tap_vld=4'hF.

Source files
------------

// File: rtl/dff_delay_line_if.sv
// Control, data and status bundle for dff_delay_line.
// master drives enable/clear/input word; slave returns last stage and occupancy.
interface dff_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             empty;

    modport master (
        output en, clr, d, d_vld,
        input  q, q_vld, cnt, full, empty
    );

    modport slave (
        input  en, clr, d, d_vld,
        output q, q_vld, cnt, full, empty
    );
endinterface

// File: rtl/dff_delay_line.sv
// DEPTH-stage data+valid delay line with enable, sync clear and occupancy count.
// Optional per-stage taps (taps/tap_vld) are built when DLY_TAPS_EN is defined.
module dff_delay_line #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic             clk,
    input logic             rst_n,
    dff_delay_line_if.slave bus
`ifdef DLY_TAPS_EN
    ,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic [DEPTH-1:0]       tap_vld
`endif
);
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: the data stages are reset as well as the valids, so q reads RST_VAL
    // while rst_n is low; the array therefore maps to flops, never to a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
            vld_q <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
            vld_q <= '0;
        end else if (bus.en) begin
            // NOTE: non-blocking, so each stage takes its neighbour's pre-edge
            // value; blocking here would collapse the pipe into a single stage.
            data_q[0] <= bus.d;
            vld_q[0]  <= bus.d_vld;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    // Word in and word out on the same edge leave the occupancy unchanged.
    always_comb begin
        // NOTE: default first, so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (bus.en) begin
            if (bus.d_vld && !vld_q[DEPTH-1]) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (!bus.d_vld && vld_q[DEPTH-1]) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.q     = data_q[DEPTH-1];
    assign bus.q_vld = vld_q[DEPTH-1];
    assign bus.cnt   = cnt_q;
    assign bus.full  = (cnt_q == CNT_W'(DEPTH));
    assign bus.empty = (cnt_q == '0);

`ifdef DLY_TAPS_EN
    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign taps[g*WIDTH +: WIDTH] = data_q[g];
    end
    assign tap_vld = vld_q;
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// Self-checking bench for dff_delay_line: DEPTH=4 instance against a queue scoreboard
// plus a DEPTH=1 instance sharing the same stimulus; table vectors and reset corner cases.
module tb_dff_delay_line;
    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] RST_VAL = 8'h00;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } word_t;

    typedef struct {
        logic       en;
        logic       clr;
        logic [7:0] d;
        logic       dv;
        logic [7:0] eq;
        logic       eqv;
        logic [2:0] ecnt;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    n_checks = 0;
    int    n_fail   = 0;
    word_t sb_q[$];   // front = last stage (q), back = stage 0
    word_t sb1;       // expected contents of the DEPTH=1 instance

    dff_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus  ();
    dff_delay_line_if #(.WIDTH(WIDTH), .DEPTH(1))     bus1 ();

    assign bus1.en    = bus.en;
    assign bus1.clr   = bus.clr;
    assign bus1.d     = bus.d;
    assign bus1.d_vld = bus.d_vld;

`ifdef DLY_TAPS_EN
    logic [WIDTH*DEPTH-1:0] taps;
    logic [DEPTH-1:0]       tap_vld;
    logic [WIDTH-1:0]       taps1;
    logic [0:0]             tap_vld1;
`endif

    dff_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus)
`ifdef DLY_TAPS_EN
        ,
        .taps   (taps),
        .tap_vld(tap_vld)
`endif
    );

    dff_delay_line #(.WIDTH(WIDTH), .DEPTH(1), .RST_VAL(RST_VAL)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus1)
`ifdef DLY_TAPS_EN
        ,
        .taps   (taps1),
        .tap_vld(tap_vld1)
`endif
    );

    always #100 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sb_popcount();
        int pc = 0;
        foreach (sb_q[i]) if (sb_q[i].vld) pc++;
        return pc;
    endfunction

    task automatic sb_clear();
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++) sb_q.push_back(word_t'({1'b0, RST_VAL}));
        sb1 = word_t'({1'b0, RST_VAL});
    endtask

    task automatic check_outputs(input string tag);
        int pc = sb_popcount();
        check({tag, ".q"},      32'(bus.q),     32'(sb_q[0].data));
        check({tag, ".q_vld"},  32'(bus.q_vld), 32'(sb_q[0].vld));
        check({tag, ".cnt"},    32'(bus.cnt),   32'(pc));
        check({tag, ".full"},   32'(bus.full),  32'(pc == DEPTH));
        check({tag, ".empty"},  32'(bus.empty), 32'(pc == 0));
        check({tag, ".q1"},     32'(bus1.q),     32'(sb1.data));
        check({tag, ".q_vld1"}, 32'(bus1.q_vld), 32'(sb1.vld));
        check({tag, ".cnt1"},   32'(bus1.cnt),   32'(sb1.vld));
        check({tag, ".full1"},  32'(bus1.full),  32'(sb1.vld));
        check({tag, ".empty1"}, 32'(bus1.empty), 32'(!sb1.vld));
`ifdef DLY_TAPS_EN
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s.tap%0d", tag, i), 32'(taps[i*WIDTH +: WIDTH]),
                  32'(sb_q[DEPTH-1-i].data));
            check($sformatf("%s.tap_vld%0d", tag, i), 32'(tap_vld[i]),
                  32'(sb_q[DEPTH-1-i].vld));
        end
`endif
    endtask

    // Drive at the falling edge, update the scoreboard at the rising edge, compare at the next fall.
    task automatic apply(input logic en, input logic clr, input logic [7:0] d, input logic dv);
        bus.en    = en;
        bus.clr   = clr;
        bus.d     = d;
        bus.d_vld = dv;
        @(posedge clk);
        if (clr) begin
            sb_clear();
        end else if (en) begin
            sb_q.push_back(word_t'({dv, d}));
            void'(sb_q.pop_front());
            sb1 = word_t'({dv, d});
        end
        @(negedge clk);
        check_outputs("cyc");
    endtask

    function automatic vec_t mk(input logic en, input logic clr, input logic [7:0] d, input logic dv,
                                input logic [7:0] eq, input logic eqv, input logic [2:0] ecnt);
        vec_t v;
        v.en = en; v.clr = clr; v.d = d; v.dv = dv;
        v.eq = eq; v.eqv = eqv; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];

        // Fill, then hold while d changes, then resume.
        vecs.push_back(mk(1, 0, 8'hA1, 1, 8'h00, 0, 3'd1));
        vecs.push_back(mk(1, 0, 8'hA2, 1, 8'h00, 0, 3'd2));
        vecs.push_back(mk(1, 0, 8'hA3, 1, 8'h00, 0, 3'd3));
        vecs.push_back(mk(1, 0, 8'hA4, 1, 8'hA1, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h55, 1, 8'hA1, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h66, 0, 8'hA1, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h77, 1, 8'hA1, 1, 3'd4));
        vecs.push_back(mk(1, 0, 8'hA5, 1, 8'hA2, 1, 3'd4));
        // Clear wins over enable; FF must never emerge.
        vecs.push_back(mk(1, 1, 8'hFF, 1, 8'h00, 0, 3'd0));
        for (int n = 0; n < 4; n++) vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 3'd0));
        // Bubbles: valid pattern 1,0,1,0 delayed by DEPTH edges, occupancy settles at 2.
        for (int n = 1; n <= 8; n++) begin
            logic [7:0] dn;
            logic [7:0] qn;
            dn = 8'h10 + 8'(n - 1);
            qn = 8'h10 + 8'(n - 4);
            if (n < 4) vecs.push_back(mk(1, 0, dn, n[0], 8'h00, 0, (n < 3) ? 3'd1 : 3'd2));
            else       vecs.push_back(mk(1, 0, dn, n[0], qn, !n[0], 3'd2));
        end

        // Reset asserted from time zero, checked between edges.
        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.clr   = 1'b0;
        bus.d     = 8'h00;
        bus.d_vld = 1'b0;
        sb_clear();
        #50;
        check_outputs("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].clr, vecs[i].d, vecs[i].dv);
            check($sformatf("tbl%0d.q", i),     32'(bus.q),     32'(vecs[i].eq));
            check($sformatf("tbl%0d.q_vld", i), 32'(bus.q_vld), 32'(vecs[i].eqv));
            check($sformatf("tbl%0d.cnt", i),   32'(bus.cnt),   32'(vecs[i].ecnt));
        end

        // Async reset between edges with data in flight (cnt=2): immediate effect.
        #50;
        rst_n = 1'b0;
        #1;
        sb_clear();
        check("async.q",     32'(bus.q),     32'(8'h00));
        check("async.q_vld", 32'(bus.q_vld), 32'(1'b0));
        check("async.cnt",   32'(bus.cnt),   32'(0));
        check("async.empty", 32'(bus.empty), 32'(1'b1));
        check_outputs("async");
        // An enabled edge while reset is held captures nothing.
        bus.en    = 1'b1;
        bus.d     = 8'hEE;
        bus.d_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;

        // Reset mid-stream at cnt=3, then B0 from the first edge after release.
        apply(1, 0, 8'hC1, 1);
        apply(1, 0, 8'hC2, 1);
        apply(1, 0, 8'hC3, 1);
        check("mid.cnt3", 32'(bus.cnt), 32'(3));
        #50;
        rst_n = 1'b0;
        #1;
        sb_clear();
        check_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 0, 8'hB0, 1);
        apply(1, 0, 8'h00, 0);
        apply(1, 0, 8'h00, 0);
        check("b0.early_vld", 32'(bus.q_vld), 32'(1'b0));
        apply(1, 0, 8'h00, 0);
        check("b0.q",     32'(bus.q),     32'(8'hB0));
        check("b0.q_vld", 32'(bus.q_vld), 32'(1'b1));
        check("b0.cnt",   32'(bus.cnt),   32'(1));

        // Clear with enable low still empties the pipe.
        apply(0, 1, 8'h55, 1);
        check("clr_noen.q_vld", 32'(bus.q_vld), 32'(1'b0));
        check("clr_noen.empty", 32'(bus.empty), 32'(1'b1));
        apply(1, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
